// File: rtl/cpu_defs.sv
// Shared definitions for the fetch pipeline: bundle width, word size and
// the default reset PC.
package cpu_defs;
  localparam int unsigned XLEN           = 32;
  localparam int unsigned IF_TO_ID_WIDTH = 64;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h1c000000;

  typedef enum logic [1:0] {
    SRAM_SIZE_BYTE = 2'd0,
    SRAM_SIZE_HALF = 2'd1,
    SRAM_SIZE_WORD = 2'd2
  } sram_size_e;
endpackage

// File: rtl/fetch_hold_buf.sv
// Holding registers for the fetch stage: an instruction word returned while
// decode was stalled, and a redirect target that could not be issued yet.
module fetch_hold_buf
  import cpu_defs::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            inst_load,
  input  logic            inst_clear,
  input  logic [XLEN-1:0] inst_in,
  input  logic            br_load,
  input  logic            br_clear,
  input  logic [XLEN-1:0] br_in,
  output logic            inst_buf_valid,
  output logic [XLEN-1:0] inst_buf,
  output logic            br_buf_valid,
  output logic [XLEN-1:0] br_buf
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      inst_buf_valid <= 1'b0;
      inst_buf       <= '0;
      br_buf_valid   <= 1'b0;
      br_buf         <= '0;
    end else begin
      // clearing (transfer or redirect) overrides a same-cycle capture
      if (inst_clear) begin
        inst_buf_valid <= 1'b0;
      end else if (inst_load) begin
        inst_buf_valid <= 1'b1;
        inst_buf       <= inst_in;
      end

      if (br_load) begin
        br_buf_valid <= 1'b1;
        br_buf       <= br_in;
      end else if (br_clear) begin
        br_buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: pre-IF issues SRAM-like requests, IF waits for the
// returned word and hands {inst, pc} to decode; redirects come from decode.
module if_stage
  import cpu_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      id_allowin,
  input  logic                      br_taken,
  input  logic [31:0]               br_target,
  output logic                      if_to_id_valid,
  output logic [IF_TO_ID_WIDTH-1:0] if_to_id_wire,
  output logic                      inst_sram_req,
  output logic                      inst_sram_wr,
  output logic [1:0]                inst_sram_size,
  output logic [3:0]                inst_sram_wstrb,
  output logic [31:0]               inst_sram_addr,
  output logic [31:0]               inst_sram_wdata,
  input  logic                      inst_sram_addr_ok,
  input  logic                      inst_sram_data_ok,
  input  logic [31:0]               inst_sram_rdata
);

  logic            preif_valid;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic            data_pending;
  logic            discard_pending;

  logic            inst_buf_valid;
  logic [XLEN-1:0] inst_buf;
  logic            br_buf_valid;
  logic [XLEN-1:0] br_buf;

  logic            fire;
  logic            accept;
  logic            data_ok_live;
  logic            if_ready_go;
  logic [XLEN-1:0] nextpc;
  logic [XLEN-1:0] inst;

  assign data_ok_live   = inst_sram_data_ok & data_pending & ~discard_pending;
  assign if_ready_go    = data_ok_live | inst_buf_valid;
  assign if_to_id_valid = resetn & if_valid & if_ready_go;
  assign fire           = if_to_id_valid & id_allowin;

  // A new request only when IF is free (or emptying now) and no stale
  // response is still owed, so at most one request is ever outstanding.
  assign inst_sram_req  = resetn & preif_valid & (~if_valid | fire) & ~discard_pending;
  assign accept         = inst_sram_req & inst_sram_addr_ok;

  assign nextpc = br_taken     ? br_target :
                  br_buf_valid ? br_buf    :
                                 if_pc + 32'd4;

  assign inst          = inst_buf_valid ? inst_buf : inst_sram_rdata;
  assign if_to_id_wire = {inst, if_pc};

  assign inst_sram_addr  = nextpc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = SRAM_SIZE_WORD;
  assign inst_sram_wstrb = '0;
  assign inst_sram_wdata = '0;

  fetch_hold_buf u_hold_buf (
    .clk            (clk),
    .resetn         (resetn),
    .inst_load      (data_ok_live & if_valid & ~fire),
    .inst_clear     (fire | br_taken),
    .inst_in        (inst_sram_rdata),
    .br_load        (br_taken & ~accept),
    .br_clear       (accept),
    .br_in          (br_target),
    .inst_buf_valid (inst_buf_valid),
    .inst_buf       (inst_buf),
    .br_buf_valid   (br_buf_valid),
    .br_buf         (br_buf)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      preif_valid     <= 1'b0;
      if_valid        <= 1'b0;
      if_pc           <= RESET_PC - 32'd4;
      data_pending    <= 1'b0;
      discard_pending <= 1'b0;
    end else begin
      preif_valid <= 1'b1;

      // an accepted request (possibly to br_target) refills IF even when a
      // redirect or transfer would otherwise empty it this cycle
      if (accept) begin
        if_valid <= 1'b1;
        if_pc    <= nextpc;
      end else if (br_taken | fire) begin
        if_valid <= 1'b0;
      end

      if (accept) begin
        data_pending <= 1'b1;
      end else if (inst_sram_data_ok) begin
        data_pending <= 1'b0;
      end

      if (br_taken & ~accept & if_valid & data_pending & ~data_ok_live) begin
        discard_pending <= 1'b1;
      end else if (inst_sram_data_ok & data_pending) begin
        discard_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed fetch/stall/redirect/reset scenarios followed by
// randomized traffic checked against a fetch-stream reference model.
module tb_if_stage;

  localparam logic [31:0] RPC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        id_allowin = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        if_to_id_valid;
  logic [63:0] if_to_id_wire;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = '0;

  if_stage #(.RESET_PC(RPC)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .id_allowin        (id_allowin),
    .br_taken          (br_taken),
    .br_target         (br_target),
    .if_to_id_valid    (if_to_id_valid),
    .if_to_id_wire     (if_to_id_wire),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_fires  = 0;
  logic [31:0] mem_q[$];     // requests accepted by memory, not yet answered
  logic [31:0] exp_q[$];     // fetched pcs still owed to decode
  logic [31:0] exp_next = RPC;
  logic        dok_real = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1c00000c) return 32'h02800421;
    return {~a[15:0], a[15:0] ^ 16'h3c5a};
  endfunction

  // One clock: drive inputs just after posedge, return at the following negedge.
  task automatic step(input logic rn, input int p_aok, input int p_dok, input int p_allow,
                      input int p_br, input int p_sp, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    resetn            = rn;
    inst_sram_addr_ok = int'($urandom_range(99)) < p_aok;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = $urandom;
    dok_real          = 1'b0;
    if (mem_q.size() != 0) begin
      if (int'($urandom_range(99)) < p_dok) begin
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = mem_word(mem_q[0]);
        dok_real          = 1'b1;
      end
    end else if (int'($urandom_range(99)) < p_sp) begin
      inst_sram_data_ok = 1'b1;
    end
    id_allowin = int'($urandom_range(99)) < p_allow;
    br_taken   = int'($urandom_range(99)) < p_br;
    br_target  = tgt;
    @(negedge clk);
  endtask

  // Reference model: the program-order fetch stream, redirected by branches.
  always @(negedge clk) begin
    if (!resetn) begin
      check("rst_req", 64'(inst_sram_req), 64'd0);
      check("rst_valid", 64'(if_to_id_valid), 64'd0);
      mem_q.delete();
      exp_q.delete();
      exp_next = RPC;
    end else begin
      if (dok_real) void'(mem_q.pop_front());
      if (if_to_id_valid) begin
        check("id_has_fetch", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          check("id_pc", 64'(if_to_id_wire[31:0]), 64'(exp_q[0]));
          check("id_inst", 64'(if_to_id_wire[63:32]), 64'(mem_word(exp_q[0])));
          if (id_allowin) begin
            void'(exp_q.pop_front());
            n_fires++;
          end
        end
      end
      if (br_taken) begin
        exp_q.delete();
        exp_next = br_target;
      end
      if (inst_sram_req && inst_sram_addr_ok) begin
        check("one_outstanding", 64'(mem_q.size()), 64'd0);
        check("fetch_addr", 64'(inst_sram_addr), 64'(exp_next));
        mem_q.push_back(inst_sram_addr);
        exp_q.push_back(inst_sram_addr);
        exp_next = inst_sram_addr + 32'd4;
      end
    end
  end

  initial begin
    int fires_before;
    int p_aok, p_dok, p_allow, p_br;

    repeat (3) step(1'b0, 0, 0, 0, 0, 0, '0);
    check("const_bus", {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata},
          {1'b0, 2'd2, 4'h0, 32'h0});

    // sustained stream: one instruction per cycle
    step(1'b1, 100, 100, 100, 0, 0, '0);
    check("preif_idle", 64'(inst_sram_req), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 100, 100, 100, 0, 0, '0);
      check("seq_req", 64'(inst_sram_req), 64'd1);
      check("seq_addr", 64'(inst_sram_addr), 64'(RPC + 32'(i * 4)));
      if (i > 0) begin
        check("seq_valid", 64'(if_to_id_valid), 64'd1);
        check("seq_pc", 64'(if_to_id_wire[31:0]), 64'(RPC + 32'((i - 1) * 4)));
      end
    end

    // decode stall while a word returns: held and delivered intact
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 100, 100, 0, 0, 0, '0);
      check("hold_req", 64'(inst_sram_req), 64'd0);
      check("hold_valid", 64'(if_to_id_valid), 64'd1);
      check("hold_wire", if_to_id_wire, {32'h02800421, 32'h1c00000c});
    end
    step(1'b1, 100, 100, 100, 0, 0, '0);
    check("release_wire", if_to_id_wire, {32'h02800421, 32'h1c00000c});
    check("release_addr", 64'(inst_sram_addr), 64'h1c000010);
    step(1'b1, 100, 100, 100, 0, 0, '0);
    check("pre_br_addr", 64'(inst_sram_addr), 64'h1c000014);

    // redirect while data for 1c000014 is still outstanding
    step(1'b1, 100, 0, 100, 100, 0, 32'h1c000100);
    check("br_wait_req", 64'(inst_sram_req), 64'd0);
    step(1'b1, 100, 100, 100, 0, 0, '0);
    check("drop_valid", 64'(if_to_id_valid), 64'd0);
    check("drop_req", 64'(inst_sram_req), 64'd0);
    step(1'b1, 100, 100, 100, 0, 0, '0);
    check("br_addr", 64'(inst_sram_addr), 64'h1c000100);

    // redirect with addr_ok low: target must be held until accepted
    step(1'b1, 0, 100, 100, 100, 0, 32'h1c000200);
    check("br_pc", 64'(if_to_id_wire[31:0]), 64'h1c000100);
    check("brbuf_first", 64'(inst_sram_addr), 64'h1c000200);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 0, 100, 100, 0, 0, '0);
      check("brbuf_req", 64'(inst_sram_req), 64'd1);
      check("brbuf_addr", 64'(inst_sram_addr), 64'h1c000200);
    end
    step(1'b1, 100, 100, 100, 0, 0, '0);
    check("brbuf_accept", 64'(inst_sram_addr), 64'h1c000200);
    step(1'b1, 100, 100, 100, 0, 0, '0);
    check("brbuf_next", 64'(inst_sram_addr), 64'h1c000204);

    // redirect in the same cycle as an accepted request
    step(1'b1, 100, 100, 100, 100, 0, 32'h1c000300);
    check("same_cyc_addr", 64'(inst_sram_addr), 64'h1c000300);
    step(1'b1, 100, 100, 100, 0, 0, '0);
    check("same_cyc_valid", 64'(if_to_id_valid), 64'd1);
    check("same_cyc_pc", 64'(if_to_id_wire[31:0]), 64'h1c000300);

    // reset with a request outstanding, stray data_ok afterwards
    step(1'b0, 0, 0, 0, 0, 100, '0);
    step(1'b0, 0, 0, 0, 0, 100, '0);
    step(1'b1, 0, 0, 0, 0, 100, '0);
    check("post_rst_valid", 64'(if_to_id_valid), 64'd0);
    check("post_rst_req", 64'(inst_sram_req), 64'd0);
    step(1'b1, 100, 100, 100, 0, 100, '0);
    check("restart_addr", 64'(inst_sram_addr), 64'(RPC));
    step(1'b1, 100, 100, 100, 0, 0, '0);
    check("restart_pc", 64'(if_to_id_wire[31:0]), 64'(RPC));

    // randomized traffic, occasional resets
    for (int b = 0; b < 8; b++) begin
      p_aok        = int'($urandom_range(100, 20));
      p_dok        = int'($urandom_range(100, 20));
      p_allow      = int'($urandom_range(100, 20));
      p_br         = int'($urandom_range(15, 0));
      fires_before = n_fires;
      for (int c = 0; c < 500; c++) begin
        step($urandom_range(199) != 0, p_aok, p_dok, p_allow, p_br, 10,
             RPC + 32'($urandom_range(255) << 2));
      end
      check("block_progress", 64'(n_fires - fires_before > 10), 64'd1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h1c000000: address of the first fetched instruction.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 id_allowin  input  1  decode stage accepts a new instruction this cycle.
REQ-005 br_taken  input  1  single-cycle redirect pulse from decode.
REQ-006 br_target  input  32  redirect address, valid when br_taken=1.
REQ-007 if_to_id_valid  output  1  fetch-to-decode bundle valid.
REQ-008 if_to_id_wire  output  64  {inst[31:0], pc[31:0]}, inst in upper half.
REQ-009 inst_sram_req  output  1  fetch request.
REQ-010 inst_sram_wr / inst_sram_size / inst_sram_wstrb / inst_sram_wdata  output  1/2/4/32  constant 0 / 2'd2 / 4'h0 / 32'h0.
REQ-011 inst_sram_addr  output  32  fetch address (nextpc).
REQ-012 inst_sram_addr_ok  input  1  request accepted when req=1.
REQ-013 inst_sram_data_ok  input  1  read data returned, in request order.
REQ-014 inst_sram_rdata  input  32  instruction word, valid with data_ok.

Function
REQ-015 Pipeline: pre-IF (issues request) -> IF (awaits data, holds instruction) -> decode; transfer IF->ID when if_to_id_valid & id_allowin ("fire").
REQ-016 preif_valid SHALL be 0 in reset and 1 from the first cycle after resetn rises.
REQ-017 nextpc priority: br_taken ? br_target : br_buf_valid ? br_buf : if_pc+4; if_pc resets to RESET_PC-4.
REQ-018 inst_sram_req = preif_valid & (~if_valid | fire) & ~discard_pending; at most one request outstanding at any time.
REQ-019 On req & addr_ok: if_valid<=1, if_pc<=nextpc, data pending set; br_buf_valid<=0.
REQ-020 if_ready_go = data_ok this cycle (not discarded) or inst_buf_valid; if_to_id_valid = if_valid & if_ready_go.
REQ-021 inst = inst_buf_valid ? inst_buf : inst_sram_rdata.
REQ-022 data_ok while IF valid and not firing: latch rdata into inst_buf, inst_buf_valid<=1; cleared on fire or br_taken.
REQ-023 br_taken while no request accepted that cycle: br_buf<=br_target, br_buf_valid<=1 (held until next accepted request).
REQ-024 br_taken & req & addr_ok same cycle: accepted address is br_target; no buffering, no cancel of that request.
REQ-025 br_taken with IF holding data (buffered or data_ok this cycle): if_valid<=0, instruction dropped.
REQ-026 br_taken with IF data still outstanding: if_valid<=0, discard_pending<=1; the next data_ok is dropped and clears discard_pending.
REQ-027 Fire and br_taken same cycle: IF still cleared; decode discards the transferred word.
REQ-028 addr_ok/data_ok when req=0 / nothing pending: ignored.
REQ-029 Throughput: with addr_ok combinational and data_ok one cycle later, one instruction per cycle sustained.

Reset
REQ-030 During resetn=0: inst_sram_req=0, if_to_id_valid=0, if_valid=0, preif_valid=0, inst_buf_valid=0, br_buf_valid=0, discard_pending=0, if_pc=RESET_PC-4.
REQ-031 Reset asserted mid-transaction SHALL abandon pending data; data_ok arriving after reset with nothing pending is ignored.

Structure
REQ-032 Shared package cpu_defs holds IF_TO_ID_WIDTH=64 and RESET_PC default.
REQ-033 One sub-module fetch_hold_buf: inst_buf and br_buf registers with valid bits; remainder inline.

Verification
REQ-034 Reset release, addr_ok=1, data_ok one cycle later -> addrs 1c000000,1c000004,1c000008 on consecutive cycles; if_to_id_valid each cycle with matching pc.
REQ-035 id_allowin=0 for 3 cycles when data_ok returns word 32'h02800421 -> req low, word held in inst_buf, delivered with pc intact when id_allowin=1.
REQ-036 br_taken, br_target=1c000100 while IF awaiting data for 1c000008 -> that data_ok dropped, next accepted addr 1c000100, no 1c000008 reaches decode.
REQ-037 br_taken with addr_ok=0 for 4 cycles -> br_buf held, first accepted addr 1c000100, then 1c000104.
REQ-038 br_taken same cycle as req&addr_ok -> accepted addr equals br_target, its data delivered normally.
REQ-039 resetn low with request outstanding -> req=0, if_to_id_valid=0 next cycle; restart fetch at 1c000000.
